// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and byte-enable generation for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // size is funct3[1:0]; signedness does not affect which lanes are enabled
  function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it to 32 bits.
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'b00:   byte_sel = rdata_i[7:0];
      2'b01:   byte_sel = rdata_i[15:8];
      2'b10:   byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      F3_W:    data_o = rdata_i;
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack handshake with a variable-latency data memory.
// Define LSU_MISALIGN_TRAP_EN to skip misaligned accesses and pulse `misaligned`.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned MISALIGN_ALLOW = 0
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        misaligned
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  lsu_state_e  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] load_data_q, load_data_d;
  logic [31:0] ext_data;

  logic req_any, legal, misal, issue;

  load_extend u_load_extend (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_lo_q),
    .rdata_i   (mem_rdata),
    .data_o    (ext_data)
  );

  always_comb begin
    req_any = MemReadM | MemWriteM;
    case (funct3M)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = ~MemWriteM;
      default:          legal = 1'b0;
    endcase
    case (funct3M[1:0])
      2'b01:   misal = ALUResultM[0];
      2'b10:   misal = |ALUResultM[1:0];
      default: misal = 1'b0;
    endcase
    // Without the trap, MISALIGN_ALLOW lets misaligned accesses through on the truncated address
    issue = legal && (!misal || (!TrapEn && (MISALIGN_ALLOW != 0)));
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    load_data_d = load_data_q;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          if (issue) begin
            state_d   = StBusy;
            req_d     = 1'b1;
            we_d      = MemWriteM;
            addr_d    = {ALUResultM[31:2], 2'b00};
            be_d      = gen_be(funct3M[1:0], ALUResultM[1:0]);
            funct3_d  = funct3M;
            addr_lo_d = ALUResultM[1:0];
            case (funct3M[1:0])
              2'b00:   wdata_d = {4{WriteDataM[7:0]}};
              2'b01:   wdata_d = {2{WriteDataM[15:0]}};
              default: wdata_d = WriteDataM;
            endcase
          end else begin
            state_d = StDone;
            if (!MemWriteM) load_data_d = 32'h0;
          end
        end
      end
      StBusy: begin
        if (mem_ack) begin
          state_d = StDone;
          req_d   = 1'b0;
          if (!we_q) load_data_d = ext_data;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= StIdle;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      funct3_q    <= 3'h0;
      addr_lo_q   <= 2'h0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      load_data_q <= load_data_d;
    end
  end

  // Gated by clr_n so reset forces the combinational outputs low too
  assign StallM = clr_n && (((state_q == StIdle) && req_any) || (state_q == StBusy));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = clr_n && (state_q == StIdle) && req_any && legal && misal;
`else
  assign misaligned = 1'b0;
`endif

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed, table-driven bench for mem_stage_lsu with a hand-driven memory responder.
module tb_mem_stage_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr_n;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        misaligned;

  int tests = 0;
  int fails = 0;

  mem_stage_lsu dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          waits;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle; ends in the following IDLE cycle with inputs dropped
  task automatic do_access(input vec_t v, input string name);
    int stalls;
    stalls     = 0;
    MemReadM   = v.rd;
    MemWriteM  = v.wr;
    funct3M    = v.f3;
    ALUResultM = v.addr;
    WriteDataM = v.wd;
    #1;
    if (StallM) stalls++;
    tick();
    chk({name, ".req"}, {31'h0, mem_req}, 32'h1);
    chk({name, ".addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
    chk({name, ".be"}, {28'h0, mem_be}, {28'h0, v.be});
    chk({name, ".wdata"}, mem_wdata, v.wdata);
    chk({name, ".we"}, {31'h0, mem_we}, {31'h0, v.wr});
    for (int i = 0; i < v.waits; i++) begin
      if (StallM) stalls++;
      tick();
      chk({name, ".req_hold"}, {31'h0, mem_req}, 32'h1);
    end
    chk({name, ".addr_hold"}, mem_addr, v.addr & 32'hFFFF_FFFC);
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    if (StallM) stalls++;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    chk({name, ".done_stall"}, {31'h0, StallM}, 32'h0);
    chk({name, ".done_req"}, {31'h0, mem_req}, 32'h0);
    chk({name, ".load_data"}, load_data, v.ld);
    chk({name, ".stall_cycles"}, stalls, v.waits + 2);
    tick();
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    #1;
    chk({name, ".no_reissue"}, {31'h0, mem_req}, 32'h0);
  endtask

  // Accesses that must not reach memory (illegal funct3 or misaligned)
  task automatic do_skip(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic exp_mis,
                         input logic [31:0] exp_ld, input string name);
    MemReadM   = rd;
    MemWriteM  = wr;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = 32'hFFFF_FFFF;
    #1;
    chk({name, ".stall"}, {31'h0, StallM}, 32'h1);
    chk({name, ".mis"}, {31'h0, misaligned}, {31'h0, exp_mis});
    tick();
    chk({name, ".done_stall"}, {31'h0, StallM}, 32'h0);
    chk({name, ".mis_end"}, {31'h0, misaligned}, 32'h0);
    chk({name, ".req"}, {31'h0, mem_req}, 32'h0);
    chk({name, ".load_data"}, load_data, exp_ld);
    tick();
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    #1;
    chk({name, ".req_idle"}, {31'h0, mem_req}, 32'h0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".stall"}, {31'h0, StallM}, 32'h0);
    chk({name, ".req"}, {31'h0, mem_req}, 32'h0);
    chk({name, ".we"}, {31'h0, mem_we}, 32'h0);
    chk({name, ".addr"}, mem_addr, 32'h0);
    chk({name, ".be"}, {28'h0, mem_be}, 32'h0);
    chk({name, ".wdata"}, mem_wdata, 32'h0);
    chk({name, ".mis"}, {31'h0, misaligned}, 32'h0);
    chk({name, ".load_data"}, load_data, 32'h0);
  endtask

  initial begin
    vec_t v;
    //          rd    wr    f3      addr        wd            rdata         w  be     wdata         ld
    vecs[0] = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 2, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0011, 0, 4'h8, 32'h0,        32'hFFFFFF80};
    vecs[2] = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0011, 0, 4'h8, 32'h0,        32'h00000080};
    vecs[3] = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        0, 4'hC, 32'hABCDABCD, 32'h00000080};
    vecs[4] = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80FF0011, 0, 4'hC, 32'h0,        32'hFFFF80FF};
    vecs[5] = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h80FF8011, 1, 4'h3, 32'h0,        32'h00008011};
    vecs[6] = '{1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        0, 4'h2, 32'hA5A5A5A5, 32'h00008011};
    vecs[7] = '{1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0,        3, 4'hF, 32'hCAFEF00D, 32'h00008011};
    vecs[8] = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0,        32'h12347F56, 0, 4'h2, 32'h0,        32'h0000007F};
    vecs[9] = '{1'b1, 1'b1, 3'b000, 32'h500, 32'h00000011, 32'h0,        0, 4'h1, 32'h11111111, 32'h0000007F};

    clr_n      = 1'b0;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    funct3M    = 3'b000;
    ALUResultM = 32'h0;
    WriteDataM = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    tick();
    tick();
    chk_all_zero("reset");
    clr_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) do_access(vecs[i], $sformatf("vec%0d", i));

    do_skip(1'b1, 1'b0, 3'b011, 32'h10, 1'b0, 32'h0, "illegal_ld");
    v = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'h55AA55AA, 0, 4'hF, 32'h0, 32'h55AA55AA};
    do_access(v, "lw_refill");
    do_skip(1'b0, 1'b1, 3'b101, 32'h30, 1'b0, 32'h55AA55AA, "illegal_st");
    do_skip(1'b1, 1'b0, 3'b010, 32'h101, Trap, 32'h0, "misalign_lw");

    // Reset while BUSY, then a stray ack after release must be ignored
    MemReadM   = 1'b1;
    funct3M    = 3'b010;
    ALUResultM = 32'h600;
    tick();
    chk("midreset.req_before", {31'h0, mem_req}, 32'h1);
    clr_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    MemReadM = 1'b0;
    tick();
    clr_n = 1'b1;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    chk("late_ack.req", {31'h0, mem_req}, 32'h0);
    chk("late_ack.stall", {31'h0, StallM}, 32'h0);
    chk("late_ack.load_data", load_data, 32'h0);
    tick();

    // Back-to-back loads: second is accepted in the IDLE cycle right after DONE
    v = '{1'b1, 1'b0, 3'b010, 32'h700, 32'h0, 32'h11111111, 0, 4'hF, 32'h0, 32'h11111111};
    do_access(v, "b2b_first");
    v = '{1'b1, 1'b0, 3'b010, 32'h704, 32'h0, 32'h22222222, 0, 4'hF, 32'h0, 32'h22222222};
    do_access(v, "b2b_second");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
